// File: rtl/icache_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
// The tag/index/offset split covers PC[9:2] of a 1024-byte instruction memory.
package icache_pkg;

    localparam int TAG_W      = 3;
    localparam int INDEX_W    = 3;
    localparam int OFFSET_W   = 2;
    localparam int BLOCK_W    = 128;
    localparam int WORD_W     = 32;
    localparam int CNT_W      = 16;

    // PC bit positions: bytes within a word, words within a line, then index, then tag.
    localparam int WORD_LSB   = 2;
    localparam int INDEX_LSB  = WORD_LSB + OFFSET_W;
    localparam int TAG_LSB    = INDEX_LSB + INDEX_W;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        READ_MEM = 2'd1,
        FILL     = 2'd2
    } icache_state_e;

    // Saturating increment used by the performance counters.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        logic [CNT_W-1:0] result;
        if (value == {CNT_W{1'b1}}) begin
            result = value;
        end else begin
            result = value + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return result;
    endfunction

endpackage

// File: rtl/icache_if.sv
// Block-read bus between the instruction cache (master) and instruction memory (slave).
// The memory holds MEM_BUSYWAIT high while busy; MEM_READDATA is valid once it falls.
interface icache_if
    import icache_pkg::*;
#(
    parameter int MEM_ADDR_W = 6
) ();

    logic                  MEM_READ;
    logic [MEM_ADDR_W-1:0] MEM_ADDRESS;
    logic [BLOCK_W-1:0]    MEM_READDATA;
    logic                  MEM_BUSYWAIT;

    modport master (
        output MEM_READ,
        output MEM_ADDRESS,
        input  MEM_READDATA,
        input  MEM_BUSYWAIT
    );

    modport slave (
        input  MEM_READ,
        input  MEM_ADDRESS,
        output MEM_READDATA,
        output MEM_BUSYWAIT
    );

endinterface

// File: rtl/icache_word_select.sv
// 4:1 word multiplexer: picks one 32-bit instruction out of a 128-bit cache line.
// Word 0 sits in bits [31:0].
module icache_word_select
    import icache_pkg::*;
(
    input  logic [BLOCK_W-1:0]  block_data,
    input  logic [OFFSET_W-1:0] word_off,
    output logic [WORD_W-1:0]   instr_word
);

    // Select the addressed word of the line.
    always_comb begin
        instr_word = block_data[31:0];
        case (word_off)
            2'd0:    instr_word = block_data[31:0];
            2'd1:    instr_word = block_data[63:32];
            2'd2:    instr_word = block_data[95:64];
            2'd3:    instr_word = block_data[127:96];
            default: instr_word = block_data[31:0];
        endcase
    end

endmodule

// File: rtl/icache_controller.sv
// Direct-mapped, read-only instruction cache between pc_unit and instruction memory.
// Hits are served combinationally. A miss raises BUSYWAIT, reads the whole 16-byte
// block over the icache_if bus and refills the line.
// Optional build macro: ICACHE_PERF_EN adds saturating HIT_COUNT / MISS_COUNT ports.
module icache_controller
    import icache_pkg::*;
#(
    parameter int NUM_LINES  = 8,
    parameter int MEM_ADDR_W = 6
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [31:0]       PC,
    output logic [WORD_W-1:0] INSTRUCTION,
    output logic              BUSYWAIT,
    icache_if.master          mem
`ifdef ICACHE_PERF_EN
    ,
    output logic [CNT_W-1:0]  HIT_COUNT,
    output logic [CNT_W-1:0]  MISS_COUNT
`endif
);

    icache_state_e        state_r;
    icache_state_e        state_nxt_s;

    logic [NUM_LINES-1:0] valid_r;
    logic [TAG_W-1:0]     tag_r  [NUM_LINES];
    logic [BLOCK_W-1:0]   data_r [NUM_LINES];

    logic [TAG_W-1:0]     tag_s;
    logic [INDEX_W-1:0]   index_s;
    logic [OFFSET_W-1:0]  offset_s;
    logic                 hit_s;
    logic                 busy_s;
    logic                 mem_read_s;
    logic                 fill_s;
    logic                 unused_pc_s;

    assign tag_s    = PC[TAG_LSB +: TAG_W];
    assign index_s  = PC[INDEX_LSB +: INDEX_W];
    assign offset_s = PC[WORD_LSB +: OFFSET_W];

    // Upper PC bits lie outside the instruction memory and the byte offset is ignored.
    assign unused_pc_s = ^{PC[31:TAG_LSB+TAG_W], PC[WORD_LSB-1:0]};

    assign hit_s = valid_r[index_s] && (tag_r[index_s] == tag_s);

    icache_word_select u_word_select (
        .block_data (data_r[index_s]),
        .word_off   (offset_s),
        .instr_word (INSTRUCTION)
    );

    // The block address is PC-derived; PC does not move while a miss is outstanding.
    assign mem.MEM_ADDRESS = PC[INDEX_LSB +: MEM_ADDR_W];
    assign mem.MEM_READ    = mem_read_s;
    // The CPU is never stalled while reset is held.
    assign BUSYWAIT        = busy_s & ~RESET;

    // Miss FSM state register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Miss FSM next-state and control outputs.
    always_comb begin
        state_nxt_s = state_r;
        busy_s      = 1'b0;
        mem_read_s  = 1'b0;
        fill_s      = 1'b0;
        case (state_r)
            IDLE: begin
                busy_s = ~hit_s;
                if (hit_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = READ_MEM;
                end
            end
            READ_MEM: begin
                busy_s     = 1'b1;
                mem_read_s = 1'b1;
                if (mem.MEM_BUSYWAIT) begin
                    state_nxt_s = READ_MEM;
                end else begin
                    state_nxt_s = FILL;
                end
            end
            FILL: begin
                busy_s      = 1'b1;
                fill_s      = 1'b1;
                state_nxt_s = IDLE;
            end
            default: begin
                busy_s      = 1'b0;
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Line valid bits: cleared by reset, set when a fill completes.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            valid_r <= {NUM_LINES{1'b0}};
        end else if (fill_s) begin
            valid_r[index_s] <= 1'b1;
        end else begin
            valid_r <= valid_r;
        end
    end

    // Line tag and data capture; a fill coinciding with reset is discarded.
    always_ff @(posedge CLK) begin
        if (fill_s && !RESET) begin
            data_r[index_s] <= mem.MEM_READDATA;
            tag_r[index_s]  <= tag_s;
        end
    end

`ifdef ICACHE_PERF_EN
    // Hit/miss counters, sampled on IDLE edges and saturating at all-ones.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            HIT_COUNT  <= {CNT_W{1'b0}};
            MISS_COUNT <= {CNT_W{1'b0}};
        end else if (state_r == IDLE) begin
            if (hit_s) begin
                HIT_COUNT <= sat_inc(HIT_COUNT);
            end else begin
                MISS_COUNT <= sat_inc(MISS_COUNT);
            end
        end else begin
            HIT_COUNT  <= HIT_COUNT;
            MISS_COUNT <= MISS_COUNT;
        end
    end
`endif

endmodule

// File: tb/tb_icache_controller.sv
// Self-checking bench for icache_controller: directed scenarios plus random fetch
// streams, checked every cycle against a line-level model of the cache.
module tb_icache_controller;
    import icache_pkg::*;

    logic        CLK   = 1'b0;
    logic        RESET = 1'b1;
    logic [31:0] PC    = 32'd0;
    logic [31:0] INSTRUCTION;
    logic        BUSYWAIT;
`ifdef ICACHE_PERF_EN
    logic [15:0] HIT_COUNT;
    logic [15:0] MISS_COUNT;
`endif

    icache_if #(.MEM_ADDR_W(6)) mem_if ();

    icache_controller #(.NUM_LINES(8), .MEM_ADDR_W(6)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .PC          (PC),
        .INSTRUCTION (INSTRUCTION),
        .BUSYWAIT    (BUSYWAIT),
        .mem         (mem_if.master)
`ifdef ICACHE_PERF_EN
        ,
        .HIT_COUNT   (HIT_COUNT),
        .MISS_COUNT  (MISS_COUNT)
`endif
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- instruction memory ----------------
    // Word w of block a is {a, w+1}, so block 0 reads 0004_0003_0002_0001.
    function automatic logic [31:0] mem_word(input logic [5:0] a, input int w);
        return {10'd0, a, 16'(w + 1)};
    endfunction

    int mem_lat   = 0;   // busy cycles per block read
    int rd_cycles = 0;

    always @(posedge CLK) rd_cycles <= mem_if.MEM_READ ? rd_cycles + 1 : 0;

    assign mem_if.MEM_BUSYWAIT = mem_if.MEM_READ && (rd_cycles < mem_lat);
    assign mem_if.MEM_READDATA = {mem_word(mem_if.MEM_ADDRESS, 3), mem_word(mem_if.MEM_ADDRESS, 2),
                                  mem_word(mem_if.MEM_ADDRESS, 1), mem_word(mem_if.MEM_ADDRESS, 0)};

    // ---------------- reference model ----------------
    // m_rem = clock cycles of stall still ahead after the last edge: a miss with
    // memory latency N costs N+1 memory-request cycles plus one fill cycle.
    bit         m_valid [8];
    logic [2:0] m_tag   [8];
    int         m_rem     = 0;
    int         m_hits    = 0;
    int         m_misses  = 0;
    bit         m_started = 1'b0;

    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[pc[6:4]] && (m_tag[pc[6:4]] == pc[9:7]);
    endfunction

    always @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < 8; i++) m_valid[i] <= 1'b0;
            m_rem     <= 0;
            m_hits    <= 0;
            m_misses  <= 0;
            m_started <= 1'b1;
        end else if (m_rem == 0) begin
            if (m_hit(PC)) m_hits <= (m_hits == 65535) ? 65535 : m_hits + 1;
            else begin
                m_misses <= (m_misses == 65535) ? 65535 : m_misses + 1;
                m_rem    <= mem_lat + 2;
            end
        end else begin
            if (m_rem == 1) begin
                m_valid[PC[6:4]] <= 1'b1;
                m_tag[PC[6:4]]   <= PC[9:7];
            end
            m_rem <= m_rem - 1;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge CLK) begin
        if (m_started) begin
            check("busywait", {31'd0, BUSYWAIT}, {31'd0, !RESET && (m_rem != 0 || !m_hit(PC))});
            check("mem_read", {31'd0, mem_if.MEM_READ}, {31'd0, m_rem >= 2});
            if (m_rem >= 2) check("mem_address", {26'd0, mem_if.MEM_ADDRESS}, {26'd0, PC[9:4]});
            if (!RESET && m_rem == 0 && m_hit(PC))
                check("instruction", INSTRUCTION, mem_word(PC[9:4], int'(PC[3:2])));
`ifdef ICACHE_PERF_EN
            check("hit_count", {16'd0, HIT_COUNT}, 32'(m_hits));
            check("miss_count", {16'd0, MISS_COUNT}, 32'(m_misses));
`endif
        end
    end

    // ---------------- directed fetch ----------------
    // Presents pc, then counts the full cycles BUSYWAIT stays high (bounded).
    task automatic fetch(input logic [31:0] pc, input int lat, input bit exp_miss,
                         input int exp_stall, input logic [31:0] exp_instr, input logic [5:0] exp_addr);
        int n;
        @(posedge CLK); #1;
        PC = pc; mem_lat = lat; RESET = 1'b0;
        @(negedge CLK);
        check("miss_flag", {31'd0, BUSYWAIT}, {31'd0, exp_miss});
        n = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge CLK);
            if (exp_miss && k == 0) begin
                check("first_mem_read", {31'd0, mem_if.MEM_READ}, 32'd1);
                check("first_mem_addr", {26'd0, mem_if.MEM_ADDRESS}, {26'd0, exp_addr});
            end
            if (!BUSYWAIT) break;
            n++;
        end
        check("stall_cycles", 32'(n), 32'(exp_stall));
        check("fetched_instr", INSTRUCTION, exp_instr);
    endtask

    initial begin
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("reset_busywait", {31'd0, BUSYWAIT}, 32'd0);
        check("reset_mem_read", {31'd0, mem_if.MEM_READ}, 32'd0);

        // Cold miss on PC 0, memory busy 5 cycles.
        fetch(32'h0000_0000, 5, 1'b1, 7, 32'h0000_0001, 6'h00);
        // Remaining words of the line hit.
        fetch(32'h0000_0004, 5, 1'b0, 0, 32'h0000_0002, 6'h00);
        fetch(32'h0000_0008, 5, 1'b0, 0, 32'h0000_0003, 6'h00);
        fetch(32'h0000_000C, 5, 1'b0, 0, 32'h0000_0004, 6'h00);
`ifdef ICACHE_PERF_EN
        check("perf_miss_after_fill", {16'd0, MISS_COUNT}, 32'd1);
        check("perf_hits_at_least_3", {31'd0, HIT_COUNT >= 16'd3}, 32'd1);
`endif
        // Conflict on index 0 replaces the line, then PC 0 misses again.
        fetch(32'h0000_0080, 2, 1'b1, 4, 32'h0008_0001, 6'h08);
        fetch(32'h0000_0000, 1, 1'b1, 3, 32'h0000_0001, 6'h00);
        // Branch from 0x0C to cold index 4.
        fetch(32'h0000_000C, 0, 1'b0, 0, 32'h0000_0004, 6'h00);
        fetch(32'h0000_0040, 3, 1'b1, 5, 32'h0004_0001, 6'h04);

        // Reset in the middle of a memory read.
        @(posedge CLK); #1;
        PC = 32'h0000_0100; mem_lat = 6;
        repeat (3) @(posedge CLK);
        #1 RESET = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        check("midmiss_reset_mem_read", {31'd0, mem_if.MEM_READ}, 32'd0);
        check("midmiss_reset_busywait", {31'd0, BUSYWAIT}, 32'd0);
        fetch(32'h0000_0100, 6, 1'b1, 8, 32'h0010_0001, 6'h10);
        // Previously filled line was invalidated; zero-latency memory costs 2 cycles.
        fetch(32'h0000_0000, 0, 1'b1, 2, 32'h0000_0001, 6'h00);

        // Random fetch stream; PC only moves when the CPU would not be stalled.
        for (int c = 0; c < 600; c++) begin
            @(posedge CLK); #1;
            if (RESET) RESET = 1'b0;
            else if ($urandom_range(0, 59) == 0) RESET = 1'b1;
            else if (m_rem == 0 && m_hit(PC) && $urandom_range(0, 2) != 0) begin
                PC = {22'd0, 3'($urandom_range(0, 1)), 3'($urandom_range(0, 3)),
                      2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
                mem_lat = $urandom_range(0, 4);
            end
        end
        RESET = 1'b0;
        repeat (12) @(posedge CLK);
        @(negedge CLK);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
